tri_driver: RTL

Host-side initiator for the triangle rasterizer handshake. Accepts one triangle command (three 3-bit vertices) from an upstream controller, transmits it on the `nt`/`xi`/`yi` vertex channel, then monitors `busy` and captures every `po`/`xo`/`yo` pixel strobe into an 8x8 coverage bitmap and a pixel count. It sits between the system controller and the rasterizer, and is the only driver of the rasterizer's input pins.

---
 rtl/tri_driver.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tri_driver.sv
// tri_driver: host-side initiator for the triangle rasterizer handshake.
// Takes one triangle command (three 3-bit vertices), sends it on nt/xi/yi,
// then watches busy and captures every po/xo/yo pixel strobe into a pixel
// count and, optionally, an 8x8 coverage bitmap.
//
// Optional feature macro: TRI_DRIVER_BITMAP_EN
//   defined     : 64-bit coverage bitmap, duplicate-pixel detection,
//                 pix_cnt counts distinct pixels.
//   not defined : bitmap and err_dup tied to 0, pix_cnt counts every strobe.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   cmd_valid    upstream command valid
//   cmd_ready    command accepted this cycle if cmd_valid (IDLE only)
//   cmd_v[17:0]  {x1,y1,x2,y2,x3,y3}, x1 in the MSBs
//   nt           new-triangle strobe (first vertex cycle)
//   xi, yi       vertex coordinates to the rasterizer
//   busy         rasterizer busy
//   po, xo, yo   pixel strobe and coordinates
//   done         one-cycle pulse at the end of a triangle
//   pix_cnt      pixels captured for the current triangle, saturates at 64
//   bitmap       bit yo*8+xo set when that pixel was strobed
//   err_timeout  sticky watchdog expiry
//   err_dup      sticky duplicate pixel strobe
module tri_driver #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TW      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [17:0] cmd_v,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic        done,
  output logic [6:0]  pix_cnt,
  output logic [63:0] bitmap,
  output logic        err_timeout,
  output logic        err_dup
);

  localparam int unsigned CW = 3;
  localparam int unsigned VW = 2 * CW;
  localparam int unsigned QW = 2 * VW;
  localparam logic [6:0]    PIX_MAX = 7'd64;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND1,
    S_SEND2,
    S_SEND3,
    S_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] cmd_q;        // vertices 2 and 3; vertex 1 is sent straight from cmd_v
  logic          busy_seen_q;
  logic [TW-1:0] wd_q;

  logic          accept;
  logic          capture;
  logic          busy_track;
  logic          wd_clr;
  logic          wd_inc;
  logic          to_hit;
  logic          nt_d;
  logic          done_d;
  logic          ready_d;
  logic [VW-1:0] vtx_d;

  // Next-state decode plus the next value of every handshake output
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    busy_track = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    to_hit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = S_SEND1;
        end
      end
      S_SEND1: begin
        capture    = po;
        busy_track = 1'b1;
        state_d    = S_SEND2;
      end
      S_SEND2: begin
        capture    = po;
        busy_track = 1'b1;
        state_d    = S_SEND3;
      end
      S_SEND3: begin
        capture    = po;
        busy_track = 1'b1;
        wd_clr     = 1'b1;
        // A busy pulse that came and went during SEND still means the
        // rasterizer took the triangle, so skip WAIT.
        state_d    = (busy_seen_q || busy) ? S_RUN : S_WAIT;
      end
      S_WAIT: begin
        capture    = po;
        busy_track = 1'b1;
        wd_inc     = 1'b1;
        if (wd_q == WD_LAST) begin
          to_hit  = 1'b1;
          state_d = S_DONE;
        end else if (busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        capture = po;
        wd_inc  = 1'b1;
        if (wd_q == WD_LAST) begin
          to_hit  = 1'b1;
          state_d = S_DONE;
        end else if (!busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    nt_d    = (state_d == S_SEND1);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);

    // SEND1 is only entered from an accept, so vertex 1 comes from cmd_v
    case (state_d)
      S_SEND1: vtx_d = cmd_v[17:12];
      S_SEND2: vtx_d = cmd_q[QW-1:VW];
      S_SEND3: vtx_d = cmd_q[VW-1:0];
      default: vtx_d = '0;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cmd_ready <= 1'b1;
      nt        <= 1'b0;
      xi        <= '0;
      yi        <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= ready_d;
      nt        <= nt_d;
      xi        <= vtx_d[VW-1:CW];
      yi        <= vtx_d[CW-1:0];
      done      <= done_d;
    end
  end

  // Command latch, busy_seen and watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= '0;
      busy_seen_q <= 1'b0;
      wd_q        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q       <= cmd_v[QW-1:0];
        busy_seen_q <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (busy_track && busy) begin
          busy_seen_q <= 1'b1;
        end
        if (to_hit) begin
          err_timeout <= 1'b1;
        end
      end

      if (wd_clr) begin
        wd_q <= '0;
      end else if (wd_inc) begin
        wd_q <= wd_q + TW'(1);
      end
    end
  end

`ifdef TRI_DRIVER_BITMAP_EN
  logic [5:0] pix_idx;
  logic       pix_dup;

  assign pix_idx = {yo, xo};
  assign pix_dup = bitmap[pix_idx];

  // Coverage bitmap; a repeated pixel flags err_dup and is not counted again
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
      bitmap  <= '0;
      err_dup <= 1'b0;
    end else if (accept) begin
      pix_cnt <= '0;
      bitmap  <= '0;
      err_dup <= 1'b0;
    end else if (capture) begin
      bitmap[pix_idx] <= 1'b1;
      if (pix_dup) begin
        err_dup <= 1'b1;
      end else if (pix_cnt != PIX_MAX) begin
        pix_cnt <= pix_cnt + 7'd1;
      end
    end
  end
`else
  logic [5:0] unused_pix;

  assign unused_pix = {yo, xo};
  assign bitmap     = '0;
  assign err_dup    = 1'b0;

  // Strobe counter only; every captured po counts, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= '0;
    end else if (capture && (pix_cnt != PIX_MAX)) begin
      pix_cnt <= pix_cnt + 7'd1;
    end
  end
`endif

endmodule
